// File: rtl/seq_scan_ctrl_pkg.sv
// Shared encodings for the serial scan controller and its 1101 detector.
package seq_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    DET_IDLE = 2'd0,
    DET_1    = 2'd1,
    DET_11   = 2'd2,
    DET_110  = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_scan_ctrl_det.sv
// Overlapping 1101 detector; hit is combinational on the bit that completes the pattern.
//
// state    | meaning
// DET_IDLE | no useful prefix seen
// DET_1    | last bit was 1
// DET_11   | last bits were 11
// DET_110  | last bits were 110
module seq_det_1101
  import seq_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic hit
);

  det_state_t state;

  assign hit = en && (state == DET_110) && (din == PATTERN[0]);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= DET_IDLE;
    end else if (en) begin
      case (state)
        DET_IDLE: state <= (din == PATTERN[3]) ? DET_1 : DET_IDLE;
        DET_1:    state <= (din == PATTERN[2]) ? DET_11 : DET_IDLE;
        DET_11:   state <= (din == PATTERN[1]) ? DET_110 : DET_11;
        // a completed 1101 leaves a trailing 1 that can start the next match
        DET_110:  state <= din ? DET_1 : DET_IDLE;
        default:  state <= DET_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serialises a captured word MSB first and counts overlapping 1101 patterns per job.
//
// state    | meaning
// ST_IDLE  | waiting for start, match_cnt holds last job's result
// ST_SHIFT | presenting bits 1..WIDTH to the detector
// ST_DONE  | one-cycle completion, done pulse
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_word,
  input  logic             abort,
  output logic             busy,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             match_flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  scan_state_t    state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]  bit_cnt;
  logic           accept;
  logic           det_hit;

  assign accept = (state == ST_IDLE) && start;

  // clearing on accept keeps a pattern from spanning two jobs
  seq_det_1101 u_det (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (ser_valid),
    .din (ser_bit),
    .hit (det_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      match_flag <= 1'b0;
      match_cnt  <= '0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      match_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SHIFT;
            busy      <= 1'b1;
            ser_valid <= 1'b1;
            ser_bit   <= data_word[WIDTH-1];
            shreg     <= {data_word[WIDTH-2:0], 1'b0};
            bit_cnt   <= '0;
            match_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
          end else begin
            if (det_hit) begin
              match_flag <= 1'b1;
              if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
            end
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              ser_valid <= 1'b0;
              ser_bit   <= 1'b0;
            end else begin
              ser_bit <= shreg[WIDTH-1];
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
          ser_bit   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: per-job cycle masks compared against hand-computed values.
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] data_word;
  logic        busy, ser_bit, ser_valid, match_flag, done;
  logic [4:0]  match_cnt;
  logic [9:0]  outs;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] flag_m, done_m, busy_m, valid_m;
  logic [15:0] ser_w;
  logic [4:0]  cnt17, cnt18;
  logic [9:0]  outs11;

  seq_scan_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_word  (data_word),
    .abort      (abort),
    .busy       (busy),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .match_flag (match_flag),
    .match_cnt  (match_cnt),
    .done       (done)
  );

  assign outs = {busy, ser_valid, ser_bit, match_flag, done, match_cnt};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // cycle 0 is the start-accept cycle; cycles 0..18 are sampled, the call returns in cycle 18
  task automatic run_job(input logic [15:0] w, input int abort_cyc, input int start_cyc,
                         input int rst_cyc);
    flag_m = '0; done_m = '0; busy_m = '0; valid_m = '0;
    ser_w = '0; cnt17 = '0; cnt18 = '0; outs11 = '1;
    for (int c = 0; c <= 18; c++) begin
      flag_m[c]  = match_flag;
      done_m[c]  = done;
      busy_m[c]  = busy;
      valid_m[c] = ser_valid;
      if (c >= 1 && c <= 16) ser_w = {ser_w[14:0], ser_bit};
      if (c == 11) outs11 = outs;
      if (c == 17) cnt17 = match_cnt;
      if (c == 18) cnt18 = match_cnt;
      rst   = (c == rst_cyc);
      abort = (c == abort_cyc);
      if (c == 0) begin
        start = 1'b1; data_word = w;
      end else if (c == start_cyc) begin
        start = 1'b1; data_word = ~w;
      end else begin
        start = 1'b0;
      end
      if (c < 18) tick;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; data_word = '0;
    tick; tick;
    chk("reset_outputs", {22'd0, outs}, 32'd0);
    rst = 1'b0; abort = 1'b1;
    tick; tick;
    chk("abort_in_idle", {22'd0, outs}, 32'd0);
    abort = 1'b0;
    tick;

    // D000 with abort asserted alongside start: start wins
    run_job(16'hD000, 0, -1, -1);
    chk("d000_flag", flag_m, 32'h0000_0020);
    chk("d000_done", done_m, 32'h0002_0000);
    chk("d000_busy", busy_m, 32'h0003_FFFE);
    chk("d000_valid", valid_m, 32'h0001_FFFE);
    chk("d000_ser", {16'd0, ser_w}, 32'h0000_D000);
    chk("d000_cnt17", {27'd0, cnt17}, 32'd1);
    chk("d000_cnt_idle", {27'd0, cnt18}, 32'd1);

    run_job(16'hDB6D, -1, -1, -1);
    chk("db6d_flag", flag_m, 32'h0002_4920);
    chk("db6d_done", done_m, 32'h0002_0000);
    chk("db6d_ser", {16'd0, ser_w}, 32'h0000_DB6D);
    chk("db6d_cnt17", {27'd0, cnt17}, 32'd5);

    run_job(16'h0006, -1, -1, -1);
    chk("b2b_first_cnt", {27'd0, cnt17}, 32'd0);
    chk("b2b_first_done", done_m, 32'h0002_0000);
    run_job(16'hA000, -1, -1, -1);
    chk("b2b_second_flag", flag_m, 32'd0);
    chk("b2b_second_cnt", {27'd0, cnt17}, 32'd0);
    chk("b2b_second_ser", {16'd0, ser_w}, 32'h0000_A000);

    run_job(16'hD000, -1, 6, -1);
    chk("busy_start_done", done_m, 32'h0002_0000);
    chk("busy_start_busy", busy_m, 32'h0003_FFFE);
    chk("busy_start_ser", {16'd0, ser_w}, 32'h0000_D000);
    chk("busy_start_cnt", {27'd0, cnt17}, 32'd1);

    run_job(16'hDDDD, 8, -1, -1);
    chk("abort_busy", busy_m, 32'h0000_01FE);
    chk("abort_valid", valid_m, 32'h0000_01FE);
    chk("abort_done", done_m, 32'd0);
    chk("abort_cnt", {27'd0, cnt18}, 32'd1);

    run_job(16'hDB6D, -1, -1, 10);
    chk("rst_mid_outs", {22'd0, outs11}, 32'd0);
    chk("rst_mid_busy", busy_m, 32'h0000_07FE);
    chk("rst_mid_done", done_m, 32'd0);

    run_job(16'hD000, -1, -1, -1);
    chk("post_rst_done", done_m, 32'h0002_0000);
    chk("post_rst_flag", flag_m, 32'h0000_0020);
    chk("post_rst_cnt", {27'd0, cnt17}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of bits in each scanned word (WIDTH >= 4).
REQ-002 SHALL have parameter CNT_W, default 5: width of the match counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: job request, sampled only while busy=0.
REQ-006 SHALL have port data_word, input, WIDTH bits: word to scan, captured when start is accepted.
REQ-007 SHALL have port abort, input, 1 bit: terminates an active job.
REQ-008 SHALL have port busy, output, 1 bit: a job is active (SHIFT or DONE).
REQ-009 SHALL have port ser_bit, output, 1 bit: serial bit currently presented to the detector.
REQ-010 SHALL have port ser_valid, output, 1 bit: ser_bit is valid.
REQ-011 SHALL have port match_flag, output, 1 bit: one-cycle pulse per detected 1101.
REQ-012 SHALL have port match_cnt, output, CNT_W bits: matches counted in the current or last job.
REQ-013 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.

Function
REQ-014 SHALL use an FSM with states IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1, the block SHALL do all of the following at the next edge: capture data_word, clear match_cnt, clear the bit counter, clear the detector, and enter SHIFT.
REQ-016 Start accept cycle = cycle 0; in SHIFT cycles 1..WIDTH the block SHALL drive ser_valid=1 and ser_bit = data_word bits MSB first, one bit per cycle.
REQ-017 The detector SHALL find overlapping 1101 patterns within one job only; a pattern spanning two jobs SHALL NOT match.
REQ-018 When the 4th pattern bit is presented in cycle k, match_cnt SHALL increment at the end of cycle k and match_flag SHALL be high in cycle k+1 only.
REQ-019 match_cnt SHALL saturate at 2^CNT_W-1.
REQ-020 After bit WIDTH the FSM SHALL enter DONE (cycle WIDTH+1), and done SHALL be 1 in that cycle only.
REQ-021 In cycle WIDTH+1, match_cnt SHALL hold the final job count.
REQ-022 DONE SHALL return to IDLE unconditionally.
REQ-023 busy SHALL be 1 in cycles 1..WIDTH+1.
REQ-024 ser_valid SHALL be 0 outside SHIFT, and ser_bit SHALL be 0 whenever ser_valid=0.
REQ-025 start while busy=1 SHALL be ignored (no queuing), and data_word SHALL NOT be re-sampled.
REQ-026 abort=1 in SHIFT SHALL return the FSM to IDLE at the next edge with no done pulse; match_cnt SHALL hold its partial value.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 If abort and start are both high in IDLE, start SHALL be accepted.
REQ-029 match_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-030 rst=1 at an edge SHALL force state=IDLE, busy=0, ser_valid=0, ser_bit=0, match_flag=0, done=0, match_cnt=0, bit counter=0, and detector state=idle.
REQ-031 rst SHALL take priority over start and abort.
REQ-032 Reset mid-SHIFT SHALL discard the job with no done pulse.
REQ-033 Outputs SHALL meet their reset values in the cycle after rst is sampled high.

Structure
REQ-034 A shared package SHALL hold the FSM state encodings (IDLE, SHIFT, DONE), the detector state encodings, and the pattern constant 4'b1101.
REQ-035 The 1101 detector SHALL be a sub-module, seq_det_1101, with inputs clk, rst, clr, en, din and output hit (combinational hit on the 4th bit); the match_flag register SHALL reside in seq_scan_ctrl.
REQ-036 The bit counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-037 The bench SHALL cover: data_word=16'hD000 -> single match_flag pulse in cycle 5; done in cycle 17 with match_cnt=1.
REQ-038 The bench SHALL cover: data_word=16'hDB6D -> overlapping matches, match_flag pulses in cycles 5, 8, 11, 14 and 17; done in cycle 17 with match_cnt=5.
REQ-039 The bench SHALL cover: back-to-back jobs 16'h0006 then 16'hA000 -> both jobs end with match_cnt=0, confirming no cross-job match.
REQ-040 The bench SHALL cover: start pulsed in cycle 6 of a job -> ignored; only one done, in cycle 17.
REQ-041 The bench SHALL cover: data_word=16'hDDDD with abort in cycle 8 -> busy=0 in cycle 9, no done, match_cnt=1.
REQ-042 The bench SHALL cover: rst in cycle 10 of a job -> all outputs at reset values in cycle 11; a new start is accepted normally afterwards.
